// File: rtl/tiny_evr.sv
// Receive-side event decoder: turns the aligned 16-bit EVR word stream into event
// strobes, distributed bus, heartbeat supervision and a seconds/ticks timestamp.
module tiny_evr #(
  parameter int EVR_CLOCK_RATE    = 125000000,
  parameter int SECONDS_WIDTH     = 32,
  parameter int HEARTBEAT_TIMEOUT = 250000000
) (
  input  logic                     evrRxClk,
  input  logic                     evrRxRst_n,
  input  logic [15:0]              evrRxWord,
  input  logic [1:0]               evrRxIsK,
  input  logic                     evrRxLinkUp,
  output logic [7:0]               distributedBus,
  output logic [7:0]               eventCode,
  output logic                     eventStrobe,
  output logic                     heartbeatStrobe,
  output logic                     heartbeatTimeout,
  output logic                     ppsStrobe,
  output logic [SECONDS_WIDTH-1:0] seconds,
  output logic                     secondsValid,
  output logic [31:0]              timestampTicks,
  output logic                     decodeError
);

  if (SECONDS_WIDTH < 1 || SECONDS_WIDTH > 63 || HEARTBEAT_TIMEOUT < 2 ||
      EVR_CLOCK_RATE < 1) begin : g_param_check
    $error("tiny_evr: parameter out of range");
  end

  localparam int HB_W = $clog2(HEARTBEAT_TIMEOUT);
  localparam int BC_W = $clog2(SECONDS_WIDTH + 2);
  localparam logic [HB_W-1:0] HB_RELOAD = HB_W'(HEARTBEAT_TIMEOUT - 1);
  localparam logic [BC_W-1:0] BC_FULL   = BC_W'(SECONDS_WIDTH);
  localparam logic [BC_W-1:0] BC_SAT    = BC_W'(SECONDS_WIDTH + 1);

  logic [15:0]              r_word;
  logic [1:0]               r_isK;
  logic                     r_linkUp;
  logic [SECONDS_WIDTH-1:0] r_shift;
  logic [BC_W-1:0]          r_bitCnt;
  logic [HB_W-1:0]          r_hbCnt;

  logic [7:0] w_lo;
  logic       w_err;
  logic       w_event;
  logic       w_shift;
  logic       w_hb;
  logic       w_pps;

  // Stage 1: capture the receiver word untouched
  always_ff @(posedge evrRxClk or negedge evrRxRst_n) begin
    if (!evrRxRst_n) begin
      r_word   <= '0;
      r_isK    <= '0;
      r_linkUp <= 1'b0;
    end else begin
      r_word   <= evrRxWord;
      r_isK    <= evrRxIsK;
      r_linkUp <= evrRxLinkUp;
    end
  end

  // Decode of the registered word; a K on either byte other than the comma is illegal
  assign w_lo    = r_word[7:0];
  assign w_err   = r_linkUp & (r_isK[1] | (r_isK[0] & (w_lo != 8'hBC)));
  assign w_event = r_linkUp & ~r_isK[0] & (w_lo != 8'h00);
  assign w_shift = w_event & ((w_lo == 8'h70) | (w_lo == 8'h71));
  assign w_hb    = w_event & (w_lo == 8'h7A);
  assign w_pps   = w_event & (w_lo == 8'h7D);

  // Stage 2: every output comes straight from a flop
  always_ff @(posedge evrRxClk or negedge evrRxRst_n) begin
    if (!evrRxRst_n) begin
      distributedBus   <= '0;
      eventCode        <= '0;
      eventStrobe      <= 1'b0;
      heartbeatStrobe  <= 1'b0;
      heartbeatTimeout <= 1'b1;
      ppsStrobe        <= 1'b0;
      seconds          <= '0;
      secondsValid     <= 1'b0;
      timestampTicks   <= '0;
      decodeError      <= 1'b0;
      r_shift          <= '0;
      r_bitCnt         <= '0;
      r_hbCnt          <= '0;
    end else begin
      eventStrobe     <= w_event;
      heartbeatStrobe <= w_hb;
      ppsStrobe       <= w_pps;
      decodeError     <= w_err;

      if (r_linkUp && !r_isK[1]) distributedBus <= r_word[15:8];
      if (w_event) eventCode <= w_lo;

      if (!r_linkUp) begin
        r_bitCnt     <= '0;
        secondsValid <= 1'b0;
      end else if (w_shift) begin
        r_shift <= (r_shift << 1) | SECONDS_WIDTH'(w_lo[0]);
        if (r_bitCnt != BC_SAT) r_bitCnt <= r_bitCnt + 1'b1;
      end else if (w_pps) begin
        r_bitCnt <= '0;
        if (r_bitCnt == BC_FULL) begin
          seconds      <= r_shift;
          secondsValid <= 1'b1;
        end else begin
          secondsValid <= 1'b0;
        end
      end

      if (w_pps) timestampTicks <= '0;
      else if (timestampTicks != 32'hFFFF_FFFF) timestampTicks <= timestampTicks + 1'b1;

      // Timeout flags once the counter has already sat at zero for a cycle,
      // giving exactly HEARTBEAT_TIMEOUT cycles from the heartbeat strobe.
      if (w_hb) begin
        r_hbCnt          <= HB_RELOAD;
        heartbeatTimeout <= 1'b0;
      end else if (r_hbCnt != '0) begin
        r_hbCnt <= r_hbCnt - 1'b1;
      end else begin
        heartbeatTimeout <= 1'b1;
      end
    end
  end

endmodule
